// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared types and constants for the alarm controller
//
// Purpose: state encoding, bus widths and a timer-width helper used by
//          alarm_controller and alarm_tick_timer.
// Contents:
//   alarm_state_e  - DISARMED / ARMED / RINGING / SNOOZE
//   TIME_W         - width of the BCD {H10,H1,M10,M1} time bus
//   SNOOZE_CNT_W   - width of the snooze-used counter
//   timer_width()  - bits needed to hold 0..max_val
package alarm_ctrl_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_e;

   localparam int TIME_W       = 16;
   localparam int SNOOZE_CNT_W = 3;

   function automatic int timer_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// rtl/alarm_tick_timer.sv - loadable down-counter advanced by the 1 Hz tick
//
// Purpose: counts whole seconds down to zero; never wraps below zero.
//          Priority is clear > load > tick.
// Parameters:
//   W             - counter width
// Ports:
//   i_Clk         in   clock
//   i_Reset       in   synchronous active-low reset
//   i_Load        in   load i_Load_Value this cycle
//   i_Load_Value  in   W  reload value
//   i_Clear       in   force the counter to zero
//   i_Tick        in   decrement by one (caller gates with state)
//   o_Zero        out  counter currently holds zero
//   o_Expire      out  this tick takes the counter from 1 to 0
module alarm_tick_timer #(
   parameter int W = 8
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         i_Load,
   input  logic [W-1:0] i_Load_Value,
   input  logic         i_Clear,
   input  logic         i_Tick,
   output logic         o_Zero,
   output logic         o_Expire
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_Clear) begin
         count_d = '0;
      end else if (i_Load) begin
         count_d = i_Load_Value;
      end else if (i_Tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_Zero = (count_q == '0);

   // The caller only ticks a timer in the state that owns it, where no load
   // or clear can coincide, so expiry needs only the tick and the count.
   assign o_Expire = i_Tick && (count_q == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm arm/ring/snooze sequencer
//
// Purpose: compares running time with alarm time and sequences the alarm
//          through DISARMED / ARMED / RINGING / SNOOZE. Ring duration and
//          snooze interval are timed in seconds from the 1 Hz pulse.
// Optional feature macro: ALARM_BEEP_EN - when defined, o_Alarm_On beeps
//          1 s on / 1 s off while ringing; otherwise it is steady.
// Parameters:
//   RING_SECONDS     ring time before auto-stop (1..255)
//   SNOOZE_MINUTES   snooze interval in minutes (1..15)
//   MAX_SNOOZE       snoozes allowed per alarm event (0..7)
// Ports:
//   i_Clk_100MHz      in   system clock
//   i_Reset           in   synchronous active-low reset
//   i_Tick_1Hz_Pulse  in   one-cycle pulse per second
//   i_Time            in   16  current time, BCD 12-hour
//   i_Time_PM         in   current time PM flag
//   i_Alarm_Time      in   16  alarm time, BCD 12-hour
//   i_Alarm_PM        in   alarm PM flag
//   i_Alarm_Enable    in   level, alarm armed
//   i_Setting         in   level, time or alarm being changed
//   i_Snooze          in   one-cycle snooze pulse
//   o_Alarm_Enabled   out  state != DISARMED
//   o_Alarm_On        out  alarm sounding
//   o_Snoozing        out  state == SNOOZE
//   o_Snooze_Count    out  3  snoozes used in current event
module alarm_controller
   import alarm_ctrl_pkg::*;
#(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 9,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic                    i_Clk_100MHz,
   input  logic                    i_Reset,
   input  logic                    i_Tick_1Hz_Pulse,
   input  logic [TIME_W-1:0]       i_Time,
   input  logic                    i_Time_PM,
   input  logic [TIME_W-1:0]       i_Alarm_Time,
   input  logic                    i_Alarm_PM,
   input  logic                    i_Alarm_Enable,
   input  logic                    i_Setting,
   input  logic                    i_Snooze,
   output logic                    o_Alarm_Enabled,
   output logic                    o_Alarm_On,
   output logic                    o_Snoozing,
   output logic [SNOOZE_CNT_W-1:0] o_Snooze_Count
);

   localparam int RING_W = timer_width(RING_SECONDS);
   localparam int SNZ_W  = timer_width(SNOOZE_MINUTES * 60);

   localparam logic [RING_W-1:0]       RING_LOAD = RING_W'(RING_SECONDS);
   localparam logic [SNZ_W-1:0]        SNZ_LOAD  = SNZ_W'(SNOOZE_MINUTES * 60);
   localparam logic [SNOOZE_CNT_W-1:0] MAX_SNZ   = SNOOZE_CNT_W'(MAX_SNOOZE);

   alarm_state_e                state_q;
   alarm_state_e                state_d;
   logic [SNOOZE_CNT_W-1:0]     cnt_q;
   logic [SNOOZE_CNT_W-1:0]     cnt_d;
   logic                        match_prev_q;
   logic                        enabled_q;
   logic                        on_q;
   logic                        snoozing_q;
   logic                        on_d;

   logic match;
   logic match_rise;
   logic ring_load;
   logic snz_load;
   logic timer_clr;
   logic ring_tick;
   logic snz_tick;
   logic ring_zero;
   logic ring_exp;
   logic snz_zero;
   logic snz_exp;

   // Setting forces match low, so releasing i_Setting on a matching minute
   // produces a fresh rising edge and the alarm still fires.
   assign match = (i_Time == i_Alarm_Time) && (i_Time_PM == i_Alarm_PM) && !i_Setting;
   assign match_rise = match && !match_prev_q;

   // Timers only see ticks in the state that owns them; a snooze pulse
   // takes priority over a ring-timer tick in the same cycle.
   assign timer_clr = !i_Alarm_Enable;
   assign ring_tick = i_Alarm_Enable && (state_q == RINGING) && i_Tick_1Hz_Pulse && !i_Snooze;
   assign snz_tick  = i_Alarm_Enable && (state_q == SNOOZE) && i_Tick_1Hz_Pulse;

   alarm_tick_timer #(.W(RING_W)) u_ring_timer (
      .i_Clk        (i_Clk_100MHz),
      .i_Reset      (i_Reset),
      .i_Load       (ring_load),
      .i_Load_Value (RING_LOAD),
      .i_Clear      (timer_clr),
      .i_Tick       (ring_tick),
      .o_Zero       (ring_zero),
      .o_Expire     (ring_exp)
   );

   alarm_tick_timer #(.W(SNZ_W)) u_snooze_timer (
      .i_Clk        (i_Clk_100MHz),
      .i_Reset      (i_Reset),
      .i_Load       (snz_load),
      .i_Load_Value (SNZ_LOAD),
      .i_Clear      (timer_clr),
      .i_Tick       (snz_tick),
      .o_Zero       (snz_zero),
      .o_Expire     (snz_exp)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ring_load = 1'b0;
      snz_load  = 1'b0;
      if (!i_Alarm_Enable) begin
         state_d = DISARMED;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            DISARMED: state_d = ARMED;
            ARMED: begin
               if (match_rise) begin
                  state_d   = RINGING;
                  ring_load = 1'b1;
                  cnt_d     = '0;
               end
            end
            RINGING: begin
               if (i_Snooze) begin
                  if (cnt_q < MAX_SNZ) begin
                     state_d  = SNOOZE;
                     snz_load = 1'b1;
                     cnt_d    = cnt_q + SNOOZE_CNT_W'(1);
                  end else begin
                     state_d = ARMED;
                     cnt_d   = '0;
                  end
               end else if (i_Tick_1Hz_Pulse && (ring_exp || ring_zero)) begin
                  // A zero count here means the timer was never loaded;
                  // treat it as expired rather than ringing forever.
                  state_d = ARMED;
                  cnt_d   = '0;
               end
            end
            SNOOZE: begin
               if (i_Tick_1Hz_Pulse && (snz_exp || snz_zero)) begin
                  state_d   = RINGING;
                  ring_load = 1'b1;
               end
            end
            default: state_d = DISARMED;
         endcase
      end
   end

`ifdef ALARM_BEEP_EN
   logic phase_q;
   logic phase_d;

   always_comb begin
      phase_d = phase_q;
      if (state_d == RINGING) begin
         if (state_q != RINGING) begin
            phase_d = 1'b1;
         end else if (i_Tick_1Hz_Pulse) begin
            phase_d = !phase_q;
         end
      end
      on_d = (state_d == RINGING) && phase_d;
   end

   always_ff @(posedge i_Clk_100MHz) begin
      if (!i_Reset) begin
         phase_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
      end
   end
`else
   always_comb begin
      on_d = (state_d == RINGING);
   end
`endif

   // State, snooze count, edge history and all outputs are registered
   // together so every output follows its cause by exactly one cycle.
   always_ff @(posedge i_Clk_100MHz) begin
      if (!i_Reset) begin
         state_q      <= DISARMED;
         cnt_q        <= '0;
         match_prev_q <= 1'b1;
         enabled_q    <= 1'b0;
         on_q         <= 1'b0;
         snoozing_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         match_prev_q <= match;
         enabled_q    <= (state_d != DISARMED);
         on_q         <= on_d;
         snoozing_q   <= (state_d == SNOOZE);
      end
   end

   assign o_Alarm_Enabled = enabled_q;
   assign o_Alarm_On      = on_q;
   assign o_Snoozing      = snoozing_q;
   assign o_Snooze_Count  = cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller
module tb_alarm_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic [15:0] time_v;
   logic        time_pm;
   logic [15:0] alarm_t;
   logic        alarm_pm;
   logic        enable;
   logic        setting;
   logic        snooze;
   logic        en_o;
   logic        on_o;
   logic        snz_o;
   logic [2:0]  cnt_o;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      logic        en;
      logic        on;
      logic        snz;
      logic [2:0]  cnt;
      string       name;
   } exp_t;

   exp_t sb[$];

   alarm_controller #(
      .RING_SECONDS   (5),
      .SNOOZE_MINUTES (1),
      .MAX_SNOOZE     (2)
   ) dut (
      .i_Clk_100MHz     (clk),
      .i_Reset          (rst_n),
      .i_Tick_1Hz_Pulse (tick),
      .i_Time           (time_v),
      .i_Time_PM        (time_pm),
      .i_Alarm_Time     (alarm_t),
      .i_Alarm_PM       (alarm_pm),
      .i_Alarm_Enable   (enable),
      .i_Setting        (setting),
      .i_Snooze         (snooze),
      .o_Alarm_Enabled  (en_o),
      .o_Alarm_On       (on_o),
      .o_Snoozing       (snz_o),
      .o_Snooze_Count   (cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares the DUT against the queued expectation for this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
         end else if (en_o !== e.en || on_o !== e.on || snz_o !== e.snz || cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL %s: got en=%b on=%b snz=%b cnt=%0d, expected en=%b on=%b snz=%b cnt=%0d",
                     e.name, en_o, on_o, snz_o, cnt_o, e.en, e.on, e.snz, e.cnt);
         end
      end
   end

   // Expected o_Alarm_On after k ticks of uninterrupted ringing.
   function automatic logic ring_on(input int k);
`ifdef ALARM_BEEP_EN
      return ((k % 2) == 0);
`else
      return (k >= 0);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Queue the outputs expected after the next clock edge with current inputs.
   task automatic expect_out(input logic en, input logic on, input logic snz,
                             input logic [2:0] cnt, input string name);
      exp_t e;
      e.cyc  = cyc + 1;
      e.en   = en;
      e.on   = on;
      e.snz  = snz;
      e.cnt  = cnt;
      e.name = name;
      sb.push_back(e);
   endtask

   // n tick periods: one tick cycle followed by nine idle cycles.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         repeat (9) step();
      end
   endtask

   task automatic start_ring(input string name);
      time_v = 16'h0729;
      step();
      time_v = 16'h0730;
      expect_out(1, 1, 0, 0, name);
      step();
   endtask

   initial begin
      rst_n    = 1'b0;
      tick     = 1'b0;
      time_v   = 16'h0730;
      time_pm  = 1'b0;
      alarm_t  = 16'h0730;
      alarm_pm = 1'b0;
      enable   = 1'b1;
      setting  = 1'b0;
      snooze   = 1'b0;
      step();

      // Reset hold with a matching time and enable high.
      for (int i = 0; i < 3; i++) begin
         expect_out(0, 0, 0, 0, "reset_hold");
         step();
      end
      rst_n = 1'b1;
      expect_out(1, 0, 0, 0, "armed_after_reset");
      step();
      expect_out(1, 0, 0, 0, "no_ring_after_reset");
      step();

      // Trigger, beep phase and auto-stop after 5 ticks.
      start_ring("trigger");
      ticks(1);
      expect_out(1, ring_on(1), 0, 0, "ring_after_1_tick");
      step();
      ticks(3);
      expect_out(1, ring_on(4), 0, 0, "ring_after_4_ticks");
      step();
      ticks(1);
      expect_out(1, 0, 0, 0, "auto_stop");
      step();
      ticks(2);
      expect_out(1, 0, 0, 0, "no_retrigger");
      step();

      // Snooze sequence up to exhaustion.
      start_ring("ring_for_snooze");
      snooze = 1'b1;
      expect_out(1, 0, 1, 1, "snooze_1");
      step();
      snooze = 1'b0;
      ticks(59);
      expect_out(1, 0, 1, 1, "snooze_1_before_end");
      step();
      ticks(1);
      expect_out(1, 1, 0, 1, "re_ring_1");
      step();
      snooze = 1'b1;
      expect_out(1, 0, 1, 2, "snooze_2");
      step();
      expect_out(1, 0, 1, 2, "snooze_ignored_in_snooze");
      step();
      snooze = 1'b0;
      ticks(60);
      expect_out(1, 1, 0, 2, "re_ring_2");
      step();
      snooze = 1'b1;
      expect_out(1, 0, 0, 0, "snooze_exhausted_stops");
      step();
      snooze = 1'b0;

      // PM mismatch, then setting mask and release.
      time_v = 16'h0729;
      step();
      time_v  = 16'h0730;
      time_pm = 1'b1;
      expect_out(1, 0, 0, 0, "pm_mismatch");
      step();
      time_pm = 1'b0;
      setting = 1'b1;
      expect_out(1, 0, 0, 0, "setting_mask");
      step();
      expect_out(1, 0, 0, 0, "setting_mask_hold");
      step();
      setting = 1'b0;
      expect_out(1, 1, 0, 0, "setting_release_rings");
      step();

      // Disable while ringing, re-enable on the matching minute.
      enable = 1'b0;
      expect_out(0, 0, 0, 0, "disable_ringing");
      step();
      enable = 1'b1;
      expect_out(1, 0, 0, 0, "reenable_no_ring");
      step();
      expect_out(1, 0, 0, 0, "reenable_no_ring_hold");
      step();

      // Disable while snoozing.
      start_ring("ring_before_disable");
      snooze = 1'b1;
      expect_out(1, 0, 1, 1, "snooze_before_disable");
      step();
      snooze = 1'b0;
      enable = 1'b0;
      expect_out(0, 0, 0, 0, "disable_snoozing");
      step();
      enable = 1'b1;
      expect_out(1, 0, 0, 0, "reenable_after_snooze");
      step();

      // Snooze and tick together on the cycle the ring timer would expire.
      start_ring("ring_for_collision");
      ticks(4);
      expect_out(1, ring_on(4), 0, 0, "collision_pre");
      step();
      snooze = 1'b1;
      tick   = 1'b1;
      expect_out(1, 0, 1, 1, "snooze_beats_tick");
      step();
      snooze = 1'b0;
      tick   = 1'b0;
      expect_out(1, 0, 1, 1, "collision_hold");
      step();

      enable = 1'b0;
      expect_out(0, 0, 0, 0, "final_disable");
      step();

      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      checks++;
      errors++;
      $display("FAIL watchdog: reached cycle %0d, expected completion before 20000", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Sequences the alarm function of the alarm clock. Compares the running time against the stored alarm time and runs the arm/ring/snooze state machine. Times ring duration and snooze intervals from the 1 Hz pulse. Sits between the timekeeping counters and the alarm LED/buzzer outputs; the display mux is unaffected.

Parameters:
RING_SECONDS, 60, ring time in seconds before auto-stop (1..255)
SNOOZE_MINUTES, 9, snooze interval in minutes (1..15)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7); once exhausted, snooze acts as stop

Ports:
i_Clk_100MHz  in  1  system clock
i_Reset  in  1  synchronous, active-low reset
i_Tick_1Hz_Pulse  in  1  one-cycle pulse, once per second
i_Time  in  16  current time, BCD {H10,H1,M10,M1}, 12-hour
i_Time_PM  in  1  current time PM flag
i_Alarm_Time  in  16  alarm time, same BCD format
i_Alarm_PM  in  1  alarm PM flag
i_Alarm_Enable  in  1  level; 1 = alarm armed
i_Setting  in  1  level; high while time or alarm is being changed
i_Snooze  in  1  one-cycle pulse (already debounced)
o_Alarm_Enabled  out  1  state != DISARMED
o_Alarm_On  out  1  alarm sounding
o_Snoozing  out  1  state == SNOOZE
o_Snooze_Count  out  3  snoozes used in the current event

Behaviour:
- Reset (i_Reset=0 at clock edge): state DISARMED; all outputs 0; timers 0; r_Match_Prev=1, so no trigger fires on the first cycle after reset.
- match = (i_Time==i_Alarm_Time) && (i_Time_PM==i_Alarm_PM) && !i_Setting. r_Match_Prev <= match every cycle in every state. match_rise = match && !r_Match_Prev.
- Enabling the alarm during an already-matching minute does not ring.
- All outputs are registered and update 1 cycle after the causing input.
- i_Alarm_Enable=0 overrides everything: next state is DISARMED, timers clear, snooze count clears.
- DISARMED -> ARMED when i_Alarm_Enable=1.
- ARMED -> RINGING on match_rise. Load ring timer with RING_SECONDS; clear snooze count.
- RINGING:
  - i_Snooze with count<MAX_SNOOZE -> SNOOZE. Load snooze timer with SNOOZE_MINUTES*60; count+1.
  - i_Snooze with count==MAX_SNOOZE -> ARMED; count clears.
  - On a tick, ring timer decrements. On the tick that reaches 0 -> ARMED; count clears.
  - If i_Snooze and a tick arrive in the same cycle, snooze wins and the ring timer is not decremented.
- SNOOZE:
  - On a tick, timer decrements. On the tick that reaches 0 -> RINGING with ring timer reloaded; count is held.
  - i_Snooze is ignored.
  - match_rise is ignored in SNOOZE and RINGING.
- Timer widths are $clog2(max+1). Timers never wrap below 0.
- o_Alarm_On = (state==RINGING), gated per the optional feature.
- A rising match while i_Setting=1 is masked; when i_Setting drops, the alarm fires only if the time still matches and r_Match_Prev was 0 (it was 0 because match was forced low).

Optional Feature:
ALARM_BEEP_EN
- Defined: a beep-phase flop is set to 1 on RINGING entry and toggles on each tick while RINGING. o_Alarm_On = RINGING && phase, giving 1 s on / 1 s off.
- Undefined: o_Alarm_On is steady high throughout RINGING; the phase flop is not built.

Decomposition:
- Package alarm_ctrl_pkg:
  - state encoding constants DISARMED=2'd0, ARMED=2'd1, RINGING=2'd2, SNOOZE=2'd3
  - TIME_W=16
  - SNOOZE_CNT_W=3
- Sub-module alarm_tick_timer: loadable down-counter advanced by i_Tick_1Hz_Pulse.
  - Ports: load, load value, clear, tick, zero flag.
  - Parameterised width.
  - Instantiated twice: ring and snooze.

Test Plan (sim params RING_SECONDS=5, SNOOZE_MINUTES=1, MAX_SNOOZE=2, tick every 10 cycles):
- Reset hold: i_Reset=0 for 3 cycles with enable=1 and time==alarm -> all outputs 0. After release and 1 cycle: o_Alarm_Enabled=1, no ring.
- Trigger and auto-stop: alarm 07:30 AM, time steps 07:29->07:30 AM -> o_Alarm_On=1 next cycle. After 5 ticks, o_Alarm_On=0 and state ARMED. Holding 07:30 does not retrigger.
- Snooze sequence: ring, then snooze -> o_Snoozing=1, count=1. After 60 ticks, ringing again. Snooze -> count=2, snooze period expires, ringing again. Third snooze -> ARMED, count=0, o_Alarm_On=0.
- PM mismatch and setting mask: time 07:30 PM vs alarm 07:30 AM -> no ring. A match arriving with i_Setting=1 -> no ring; i_Setting falls with match still true -> ring 1 cycle later.
- Disable mid-event: enable=0 during RINGING and again during SNOOZE -> next cycle all outputs 0. Re-enable during the matching minute -> no ring.
- Simultaneous snooze and tick on the cycle the ring timer would hit 0 -> SNOOZE entered, count=1. With ALARM_BEEP_EN: o_Alarm_On toggles on each tick and is high on RINGING entry.
